// File: rtl/line_clear_sequencer.sv
// Scans the board top to bottom after a piece locks and sequences one clear phase per full row.
// Latency ROWS+1 cycles from start to done, plus CLEAR_CYCLES+1 per full row; no backpressure: start is ignored while busy.
module line_clear_sequencer #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int CLEAR_CYCLES = 11
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             start,
    input  logic [ROWS-1:0][COLS-1:0][3:0]   PixelMap,
    output logic [4:0]                       CheckClear,
    output logic [ROWS-1:0]                  line_flags,
    output logic                             clear_en,
    output logic                             busy,
    output logic                             done,
    output logic [4:0]                       lines_cleared,
    output logic [15:0]                      total_lines
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLEAR_CYCLES - 1);
    localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CLEAR,
        SETTLE,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [ROWS-1:0] row_full;
    logic            cur_full;

    always_comb begin
        row_full = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (PixelMap[r][c] == 4'd0) begin
                    row_full[r] = 1'b0;
                end
            end
        end
    end

    assign cur_full = row_full[CheckClear];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            CheckClear    <= '0;
            line_flags    <= '0;
            clear_en      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= CHECK;
                        CheckClear    <= '0;
                        lines_cleared <= '0;
                        busy          <= 1'b1;
                    end
                end
                CHECK: begin
                    if (cur_full) begin
                        state         <= CLEAR;
                        cnt           <= CNT_LOAD;
                        clear_en      <= 1'b1;
                        line_flags    <= ROWS'(1) << CheckClear;
                        lines_cleared <= lines_cleared + 5'd1;
                        if (total_lines != 16'hFFFF) begin
                            total_lines <= total_lines + 16'd1;
                        end
                    end else if (CheckClear < LAST_ROW) begin
                        CheckClear <= CheckClear + 5'd1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        state      <= SETTLE;
                        clear_en   <= 1'b0;
                        line_flags <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // One idle cycle lets the shifted board reach PixelMap before the next row is tested.
                SETTLE: begin
                    if (CheckClear < LAST_ROW) begin
                        state      <= CHECK;
                        CheckClear <= CheckClear + 5'd1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
